// File: rtl/csr_regfile.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc/mcause/mip with trap entry and MRET.
// Define CSR_MCYCLE_EN to add a 64-bit cycle counter at 0xB00 (low) / 0xB80 (high).
module csr_regfile #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [11:0]   csr_addr,
    input  logic [1:0]    csr_op,
    input  logic [DW-1:0] csr_wdata,
    output logic [DW-1:0] csr_rdata,
    input  logic [DW-1:0] pc_in,
    input  logic          timer_irq,
    input  logic          ext_irq,
    input  logic          intr_flag,
    input  logic          is_mret,
    output logic [DW-1:0] mstatus_reg,
    output logic [DW-1:0] mie_reg,
    output logic [DW-1:0] mtvec_reg,
    output logic [DW-1:0] mepc_reg,
    output logic [DW-1:0] mcause_reg,
    output logic [DW-1:0] mip_reg,
    output logic          illegal_csr
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
`endif

    localparam logic [DW-1:0] MSTATUS_MASK = DW'(32'h0000_0088);
    localparam logic [DW-1:0] MIE_MASK     = DW'(32'h0000_0880);
    localparam logic [DW-1:0] MTVEC_MASK   = ~(DW'(32'h0000_0002));
    localparam logic [DW-1:0] MEPC_MASK    = ~(DW'(32'h0000_0003));
    localparam logic [DW-1:0] CAUSE_EXT    = {1'b1, (DW-1)'(11)};
    localparam logic [DW-1:0] CAUSE_TIMER  = {1'b1, (DW-1)'(7)};

    logic [DW-1:0] mstatus_q, mstatus_d;
    logic [DW-1:0] mie_q, mie_d;
    logic [DW-1:0] mtvec_q, mtvec_d;
    logic [DW-1:0] mepc_q, mepc_d;
    logic [DW-1:0] mcause_q, mcause_d;
    logic [DW-1:0] mip_q, mip_d;
`ifdef CSR_MCYCLE_EN
    logic [63:0]   mcycle_q, mcycle_d;
`endif

    logic          csr_we;
    logic          csr_mapped;
    logic [DW-1:0] rdata_c;
    logic [DW-1:0] wval;

    // Read mux and operand merge; wval is the raw (unmasked) value the instruction asks for.
    always_comb begin
        csr_we     = (csr_op != 2'b00);
        csr_mapped = 1'b1;
        rdata_c    = '0;
        case (csr_addr)
            ADDR_MSTATUS: rdata_c = mstatus_q;
            ADDR_MIE:     rdata_c = mie_q;
            ADDR_MTVEC:   rdata_c = mtvec_q;
            ADDR_MEPC:    rdata_c = mepc_q;
            ADDR_MCAUSE:  rdata_c = mcause_q;
            ADDR_MIP:     rdata_c = mip_q;
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:  rdata_c = DW'(mcycle_q[31:0]);
            ADDR_MCYCLEH: rdata_c = DW'(mcycle_q[63:32]);
`endif
            default:      csr_mapped = 1'b0;
        endcase
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rdata_c | csr_wdata;
            2'b11:   wval = rdata_c & ~csr_wdata;
            default: wval = rdata_c;
        endcase
    end

    assign csr_rdata   = rdata_c;
    assign illegal_csr = csr_we & ~csr_mapped;

    always_comb begin
        mstatus_d = mstatus_q;
        mie_d     = mie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mip_d     = '0;
        mip_d[7]  = timer_irq;
        mip_d[11] = ext_irq;

        if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: mstatus_d = wval & MSTATUS_MASK;
                ADDR_MIE:     mie_d     = wval & MIE_MASK;
                ADDR_MTVEC:   mtvec_d   = wval & MTVEC_MASK;
                ADDR_MEPC:    mepc_d    = wval & MEPC_MASK;
                ADDR_MCAUSE:  mcause_d  = wval;
                default:      ;
            endcase
        end

        // Trap and MRET are applied last so they override a same-cycle CSR write.
        if (intr_flag) begin
            mepc_d       = pc_in & MEPC_MASK;
            mcause_d     = (mie_q[11] & mip_q[11]) ? CAUSE_EXT : CAUSE_TIMER;
            mstatus_d    = '0;
            mstatus_d[7] = mstatus_q[3];
        end else if (is_mret) begin
            mstatus_d    = '0;
            mstatus_d[3] = mstatus_q[7];
            mstatus_d[7] = 1'b1;
        end
    end

`ifdef CSR_MCYCLE_EN
    // A CSR write to either half replaces it and holds the counter for that cycle.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (csr_we && csr_addr == ADDR_MCYCLE) begin
            mcycle_d = {mcycle_q[63:32], wval[31:0]};
        end else if (csr_we && csr_addr == ADDR_MCYCLEH) begin
            mcycle_d = {wval[31:0], mcycle_q[31:0]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q <= '0;
            mie_q     <= '0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mip_q     <= '0;
`ifdef CSR_MCYCLE_EN
            mcycle_q  <= '0;
`endif
        end else begin
            mstatus_q <= mstatus_d;
            mie_q     <= mie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mip_q     <= mip_d;
`ifdef CSR_MCYCLE_EN
            mcycle_q  <= mcycle_d;
`endif
        end
    end

    assign mstatus_reg = mstatus_q;
    assign mie_reg     = mie_q;
    assign mtvec_reg   = mtvec_q;
    assign mepc_reg    = mepc_q;
    assign mcause_reg  = mcause_q;
    assign mip_reg     = mip_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: driver pushes expected per-cycle outputs into a queue,
// a negedge monitor pops and compares. Covers CSR_MCYCLE_EN when defined.
module tb_csr_regfile;
  localparam int DW = 32;
  localparam int W  = 7 * DW + 1;

  logic          clk;
  logic          rst_n;
  logic [11:0]   csr_addr;
  logic [1:0]    csr_op;
  logic [DW-1:0] csr_wdata;
  logic [DW-1:0] csr_rdata;
  logic [DW-1:0] pc_in;
  logic          timer_irq;
  logic          ext_irq;
  logic          intr_flag;
  logic          is_mret;
  logic [DW-1:0] mstatus_reg, mie_reg, mtvec_reg, mepc_reg, mcause_reg, mip_reg;
  logic          illegal_csr;

  csr_regfile #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .pc_in(pc_in),
    .timer_irq(timer_irq), .ext_irq(ext_irq), .intr_flag(intr_flag),
    .is_mret(is_mret), .mstatus_reg(mstatus_reg), .mie_reg(mie_reg),
    .mtvec_reg(mtvec_reg), .mepc_reg(mepc_reg), .mcause_reg(mcause_reg),
    .mip_reg(mip_reg), .illegal_csr(illegal_csr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // reference model state (architectural view)
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip;
`ifdef CSR_MCYCLE_EN
  logic [63:0] m_mcycle;
`endif

  function automatic logic model_mapped(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344: return 1'b1;
`ifdef CSR_MCYCLE_EN
      12'hB00, 12'hB80: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
`ifdef CSR_MCYCLE_EN
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called at posedge+1; applies one cycle of inputs and advances the model
  task automatic drive(input logic rst, input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic [31:0] pc, input logic tirq,
                       input logic eirq, input logic intr, input logic mret);
    logic [31:0] old_v, nv;
    logic [31:0] n_mstatus, n_mie, n_mtvec, n_mepc, n_mcause, n_mip;
    logic        ill;
`ifdef CSR_MCYCLE_EN
    logic [63:0] n_mcycle;
`endif
    rst_n = rst; csr_addr = a; csr_op = op; csr_wdata = wd; pc_in = pc;
    timer_irq = tirq; ext_irq = eirq; intr_flag = intr; is_mret = mret;

    old_v = model_read(a);
    ill   = (op != 2'b00) && !model_mapped(a);
    exp_q.push_back({ill, old_v, m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip});

    case (op)
      2'b01:   nv = wd;
      2'b10:   nv = old_v | wd;
      2'b11:   nv = old_v & ~wd;
      default: nv = old_v;
    endcase
    n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec;
    n_mepc = m_mepc; n_mcause = m_mcause;
`ifdef CSR_MCYCLE_EN
    n_mcycle = m_mcycle + 64'd1;
`endif
    if (op != 2'b00) begin
      case (a)
        12'h300: n_mstatus = nv & 32'h0000_0088;
        12'h304: n_mie     = nv & 32'h0000_0880;
        12'h305: n_mtvec   = nv & 32'hFFFF_FFFD;
        12'h341: n_mepc    = nv & 32'hFFFF_FFFC;
        12'h342: n_mcause  = nv;
`ifdef CSR_MCYCLE_EN
        12'hB00: n_mcycle  = {m_mcycle[63:32], nv};
        12'hB80: n_mcycle  = {nv, m_mcycle[31:0]};
`endif
        default: ;
      endcase
    end
    if (intr) begin
      n_mepc    = {pc[31:2], 2'b00};
      n_mcause  = (m_mie[11] && m_mip[11]) ? 32'h8000_000B : 32'h8000_0007;
      n_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else if (mret) begin
      n_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end
    n_mip = (tirq ? 32'h80 : 32'h0) | (eirq ? 32'h800 : 32'h0);
    if (!rst) begin
      n_mstatus = '0; n_mie = '0; n_mtvec = '0; n_mepc = '0; n_mcause = '0; n_mip = '0;
`ifdef CSR_MCYCLE_EN
      n_mcycle = '0;
`endif
    end

    @(posedge clk);
    #1;
    m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec;
    m_mepc = n_mepc; m_mcause = n_mcause; m_mip = n_mip;
`ifdef CSR_MCYCLE_EN
    m_mcycle = n_mcycle;
`endif
  endtask

  task automatic idle(input logic tirq, input logic eirq);
    drive(1'b1, 12'h000, 2'b00, 32'h0, 32'h0, tirq, eirq, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("illegal_csr", {31'h0, illegal_csr}, {31'h0, e[W-1]});
      check("csr_rdata",   csr_rdata,   e[7*DW-1:6*DW]);
      check("mstatus_reg", mstatus_reg, e[6*DW-1:5*DW]);
      check("mie_reg",     mie_reg,     e[5*DW-1:4*DW]);
      check("mtvec_reg",   mtvec_reg,   e[4*DW-1:3*DW]);
      check("mepc_reg",    mepc_reg,    e[3*DW-1:2*DW]);
      check("mcause_reg",  mcause_reg,  e[2*DW-1:DW]);
      check("mip_reg",     mip_reg,     e[DW-1:0]);
    end
  end

  logic [11:0] addr_tbl [10];

  initial begin
    addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                 12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h000};
    rst_n = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0; pc_in = '0;
    timer_irq = 1'b0; ext_irq = 1'b0; intr_flag = 1'b0; is_mret = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_mstatus = '0; m_mie = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0; m_mip = '0;
`ifdef CSR_MCYCLE_EN
    m_mcycle = '0;
`endif

    // reset values read back through csr_rdata
    for (int i = 0; i < 6; i++) drive(1'b1, addr_tbl[i], 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // write masks
    drive(1'b1, 12'h305, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mtvec_mask", mtvec_reg, 32'hFFFF_FFFD);
    drive(1'b1, 12'h300, 2'b10, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mstatus_mask", mstatus_reg, 32'h0000_0088);
    drive(1'b1, 12'h341, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mepc_mask", mepc_reg, 32'hFFFF_FFFC);
    drive(1'b1, 12'h341, 2'b11, 32'h0000_00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // external-priority trap then MRET
    drive(1'b1, 12'h300, 2'b01, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 12'h304, 2'b01, 32'h0000_0880, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    drive(1'b1, 12'h000, 2'b00, 32'h0, 32'h0000_0123, 1'b1, 1'b1, 1'b1, 1'b0);
    check("trap_mepc", mepc_reg, 32'h0000_0120);
    check("trap_mcause", mcause_reg, 32'h8000_000B);
    check("trap_mstatus", mstatus_reg, 32'h0000_0080);
    drive(1'b1, 12'h000, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("mret_mstatus", mstatus_reg, 32'h0000_0088);
    check("mret_mepc", mepc_reg, 32'h0000_0120);

    // trap and MRET together, with a CSR write to mstatus and to mtvec
    drive(1'b1, 12'h300, 2'b11, 32'hFFFF_FFFF, 32'h0000_0456, 1'b1, 1'b1, 1'b1, 1'b1);
    check("both_mstatus", mstatus_reg, 32'h0000_0080);
    drive(1'b1, 12'h305, 2'b01, 32'h0000_1001, 32'h0000_0777, 1'b1, 1'b0, 1'b1, 1'b0);
    check("trap_mtvec_commit", mtvec_reg, 32'h0000_1001);

    // timer-only cause
    drive(1'b1, 12'h300, 2'b01, 32'h0000_0008, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 12'h000, 2'b00, 32'h0, 32'h0000_0AA8, 1'b1, 1'b0, 1'b1, 1'b0);
    check("timer_mcause", mcause_reg, 32'h8000_0007);

    // unmapped and read-only addresses
    drive(1'b1, 12'h7C0, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 12'h344, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mip_ro", mip_reg, 32'h0000_0800);
    drive(1'b1, 12'h342, 2'b01, 32'h1234_5677, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset beats a same-cycle write and trap
    drive(1'b0, 12'h305, 2'b01, 32'hFFFF_FFFF, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_mtvec", mtvec_reg, 32'h0);
    idle(1'b0, 1'b0);

`ifdef CSR_MCYCLE_EN
    drive(1'b1, 12'hB00, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 12'hB80, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    csr_addr = 12'hB00;
    #1;
    check("mcycle_wrap_lo", csr_rdata, 32'h0);
    drive(1'b1, 12'hB00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 12'hB80, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    csr_addr = 12'hB00; csr_op = 2'b01;
    #1;
    check("mcycle_absent", {31'h0, illegal_csr}, 32'h1);
    drive(1'b1, 12'hB80, 2'b10, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) != 0), addr_tbl[$urandom_range(0, 9)],
            2'($urandom_range(0, 3)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    idle(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
